cs_window_approx: RTL
=====================

Name: cs_window_approx

Overview:
- Parametrised successor to the fixed 9-sample, 8-bit computational-system block. It keeps a sliding window of the last N accepted samples and a running sum. It finds the approximate average X_appr, which is the largest window sample x with N*x <= Sum.
- Output is either the CS result floor((Sum + N*X_appr) / (N-1)) or X_appr itself, selected per sample.
- Differences from the fixed block: input-valid handshake, warm-up qualification, synchronous flush, and a registered 2-stage compute pipeline with out_valid.

Parameters:
- W, 8, sample width in bits.
- N, 9, window depth. N-1 must be a power of two (3, 5, 9, 17). Other values are a fatal elaboration error.
- SHIFT, log2(N-1), derived divide shift, 3 at the default. Not overridable.
- SUM_W, W+clog2(N), running-sum width, 12 at the default.

Ports:
- clk, input, 1, rising-edge clock.
- reset, input, 1, asynchronous active-high reset.
- in_valid, input, 1, x is accepted on a rising edge while high.
- x, input, W, sample.
- mode, input, 1, captured with the sample. 0 = CS output, 1 = X_appr output.
- flush, input, 1, synchronous clear of window, count and pipeline.
- y, output, W+2, result.
- out_valid, output, 1, one-cycle pulse per qualified result.

Behaviour:
- Reset (async, immediate):
  - Window regs, Sum, fill count, and all stage regs and valids go to 0.
  - y = 0 and out_valid = 0.
  - Reset mid-pipeline discards all in-flight results.
- Stage 0, accept edge, when in_valid=1 and flush=0:
  - Shift the window: slot1 <= x, slotk <= slot(k-1).
  - Sum <= Sum - slotN + x, in SUM_W bits. Sum never overflows because it is a sum of N W-bit values.
  - fill <= min(fill+1, N).
  - The stage-1 valid is set only if the window is full after this edge (fill was N-1 or N). mode is latched alongside.
- in_valid=0: window, Sum and fill hold, and no result is generated. Gaps of any length are legal.
- Stage 1, the edge after accept:
  - For every slot, qualify the value if N*slot <= Sum, in SUM_W bits.
  - X_appr = max of the qualified slots, else 0.
  - With a full window the minimum sample always qualifies, so the 0 fallback is unreachable in qualified results.
  - Register X_appr, Sum, mode and valid.
- Stage 2, the next edge:
  - mode=0: y = (Sum + N*X_appr) >> SHIFT, computed in SUM_W+1 bits and truncated to W+2. The result always fits.
  - mode=1: y = X_appr, zero-extended.
  - out_valid = stage-1 valid.
- Latency and timing:
  - Latency is 2 cycles: a sample accepted at edge k yields out_valid=1 and y from edge k+2 until edge k+3.
  - y holds its last value when out_valid=0.
  - Throughput is one result per cycle with continuous in_valid.
- Warm-up:
  - The first N-1 accepted samples after reset or flush produce no out_valid.
  - The Nth and each later accepted sample produce one result each.
- Flush:
  - Clears the window, Sum, fill and both stage valids on that edge.
  - Results in flight are dropped and out_valid is 0 from the next edge.
  - y holds its last value.
  - flush and in_valid together: flush wins and the sample is dropped.
- Eviction:
  - When the window is full, the oldest sample leaves the window and the sum on each accept.
  - Before full, empty slots hold 0. Their contribution is irrelevant because those results are unqualified.

Test Plan:
- Defaults, mode=0, samples 1,2,...,9 back-to-back.
  - No out_valid for samples 1-8.
  - Two cycles after sample 9: Sum=45, X_appr=5, y=90>>3=11, out_valid pulses.
- Defaults, 9 samples of 255 with mode=0 -> y=573. Repeat with mode=1 -> y=255.
- Defaults, continuous stream 1..9 then 100 (mode=0), which evicts 1.
  - Window 2..9,100 gives Sum=144 and X_appr=9, 9*9=81<=144.
  - y=(144+81)>>3=28, appearing on the cycle after the y=11 result.
- N=5, W=8, samples 2,4,6,8,10 -> Sum=30, X_appr=6, y=(30+30)>>2=15. Same with mode=1 -> y=6.
- Flush in warm-up and mid-stream:
  - Load 9 samples, assert flush together with a 10th in_valid.
  - No out_valid for the dropped sample or for the in-flight sample-9 result.
  - After the flush, 8 more samples give no out_valid, and the 9th gives a correct result.
- Async reset and gaps:
  - Assert reset between clock edges while a result is in flight. y and out_valid drop to 0 immediately, without a clock edge.
  - After release, warm-up restarts.
  - Inserting in_valid=0 gaps between samples changes neither Sum nor the results.

Source files
------------

// File: rtl/cs_window_approx.sv
// cs_window_approx
//   Sliding-window "computational system" block. Keeps the last N accepted
//   samples and their running sum. It finds the approximate average X_appr,
//   the largest window sample x with N*x <= Sum. Per sample it outputs either
//   floor((Sum + N*X_appr) / (N-1)) or X_appr.
//   Pipeline: accept edge (window/sum update) -> stage 1 (X_appr search,
//   registered) -> stage 2 (output arithmetic, registered). Latency is 2 edges.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_valid   x/mode are accepted on a rising edge while high
//   x          sample, W bits
//   mode       captured with the sample: 0 = CS result, 1 = X_appr
//   flush      synchronous clear of window, sum, fill count and pipeline
//   y          result, W+2 bits, holds its value between results
//   out_valid  one-cycle pulse per qualified result
//
// Handshake: there is no back-pressure. A sample is taken on every rising
// edge where in_valid=1 and flush=0. Each taken sample that leaves the window
// full yields exactly one out_valid pulse two edges later. flush dominates
// in_valid.

module cs_window_approx #(
    parameter int W = 8,
    parameter int N = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [W-1:0] x,
    input  logic         mode,
    input  logic         flush,
    output logic [W+1:0] y,
    output logic         out_valid
);

    localparam int SHIFT  = $clog2(N - 1);
    localparam int SUM_W  = W + $clog2(N);
    localparam int FILL_W = $clog2(N + 1);

    // Dividing by N-1 is done with a shift, so N-1 has to be a power of two.
    generate
        if (N < 3 || ((N - 1) & (N - 2)) != 0) begin : g_bad_n
            $fatal(1, "cs_window_approx: N-1 must be a power of two and N >= 3");
        end
    endgenerate

    localparam logic [SUM_W-1:0] N_S  = SUM_W'(N);
    localparam logic [SUM_W:0]   N_S1 = (SUM_W + 1)'(N);
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(N - 1);

    // ------------------------------------------------------------------
    // Stage 0: window, running sum, fill count
    // ------------------------------------------------------------------
    logic [W-1:0]      win [N];   // win[0] newest, win[N-1] oldest
    logic [SUM_W-1:0]  sum;
    logic [FILL_W-1:0] fill;
    logic              acc_v;     // accepted sample left the window full
    logic              acc_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N; i++) win[i] <= '0;
            sum      <= '0;
            fill     <= '0;
            acc_v    <= 1'b0;
            acc_mode <= 1'b0;
        end else if (flush) begin
            // Empty slots must read as 0 so the sum stays exact while refilling.
            for (int i = 0; i < N; i++) win[i] <= '0;
            sum      <= '0;
            fill     <= '0;
            acc_v    <= 1'b0;
            acc_mode <= 1'b0;
        end else begin
            acc_v <= 1'b0;
            if (in_valid) begin
                win[0] <= x;
                for (int i = 1; i < N; i++) win[i] <= win[i-1];
                // Modular subtract/add: the true sum always fits SUM_W bits.
                sum <= sum - SUM_W'(win[N-1]) + SUM_W'(x);
                if (fill != FILL_FULL) fill <= fill + 1'b1;
                acc_v    <= (fill >= FILL_LAST);
                acc_mode <= mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 1: X_appr = max slot with N*slot <= Sum (0 if none qualifies)
    // ------------------------------------------------------------------
    logic [W-1:0] x_appr;

    always_comb begin
        x_appr = '0;
        for (int i = 0; i < N; i++) begin
            if ((N_S * SUM_W'(win[i])) <= sum && win[i] > x_appr) begin
                x_appr = win[i];
            end
        end
    end

    logic              s1_v;
    logic [W-1:0]      s1_x;
    logic [SUM_W-1:0]  s1_sum;
    logic              s1_mode;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_v    <= 1'b0;
            s1_x    <= '0;
            s1_sum  <= '0;
            s1_mode <= 1'b0;
        end else if (flush) begin
            s1_v <= 1'b0;
        end else begin
            s1_v <= acc_v;
            if (acc_v) begin
                s1_x    <= x_appr;
                s1_sum  <= sum;
                s1_mode <= acc_mode;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: output arithmetic. Sum + N*X_appr <= 2*Sum, so one extra bit
    // is enough before the divide-by-(N-1) shift.
    // ------------------------------------------------------------------
    logic [SUM_W:0] cs_sum;
    logic [W+1:0]   cs_y;

    assign cs_sum = (SUM_W + 1)'(s1_sum) + N_S1 * (SUM_W + 1)'(s1_x);
    assign cs_y   = (W + 2)'(cs_sum >> SHIFT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            y         <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else begin
            out_valid <= s1_v;
            if (s1_v) begin
                y <= s1_mode ? (W + 2)'(s1_x) : cs_y;
            end
        end
    end

endmodule
